// File: rtl/wasm_host_pkg.sv
// Shared definitions for the WASM host loader: FSM state encodings,
// core status constants and default parameter values.
package wasm_host_pkg;

    localparam int unsigned DEF_INSTR_W     = 64;
    localparam int unsigned DEF_ADDR_W      = 15;
    localparam int unsigned DEF_LINE_ADDR_W = 9;
    localparam int unsigned DEF_LINE_W      = 32;
    localparam int unsigned DEF_TIMEOUT     = 32'd1 << 24;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_PACK  = 3'd1;
    localparam state_t ST_WRITE = 3'd2;
    localparam state_t ST_FIN   = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_RADDR = 3'd5;
    localparam state_t ST_RDATA = 3'd6;
    localparam state_t ST_OUT   = 3'd7;

    localparam logic [1:0] WS_DONE = 2'b11;

endpackage

// File: rtl/wasm_byte_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
// The packed word is held until the downstream side takes it.
module wasm_byte_packer #(
    parameter int unsigned WORD_W = wasm_host_pkg::DEF_INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [7:0]        in_data,
    output logic              in_last,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [WORD_W-1:0] out_data
);

    localparam int unsigned NB = WORD_W / 8;
    localparam int unsigned CW = $clog2(NB + 1);

    logic [CW-1:0]     cnt;
    logic              full;
    logic [WORD_W-1:0] word;

    assign in_rdy   = !full;
    assign in_last  = (cnt == CW'(NB - 1));
    assign out_vld  = full;
    assign out_data = word;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            full <= 1'b0;
            word <= '0;
        end else if (in_vld && !full) begin
            // shift right so the first byte ends up in the lowest lane
            word <= (word >> 8) | (WORD_W'(in_data) << (WORD_W - 8));
            if (in_last) begin
                cnt  <= '0;
                full <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (full && out_rdy) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/wasm_host_loader.sv
// Host-side loader: packs bytes into instruction words, writes them to the core,
// waits for completion (with timeout) and streams a line-memory range back out.
module wasm_host_loader
    import wasm_host_pkg::*;
#(
    parameter int unsigned INSTR_W     = DEF_INSTR_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned LINE_ADDR_W = DEF_LINE_ADDR_W,
    parameter int unsigned LINE_W      = DEF_LINE_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [ADDR_W:0]        i_word_count,
    input  logic [LINE_ADDR_W-1:0] i_rb_base,
    input  logic [LINE_ADDR_W:0]   i_rb_count,
    input  logic                   i_byte_vld,
    output logic                   o_byte_rdy,
    input  logic [7:0]             i_byte_data,
    output logic                   o_instr_mem_wr_vld,
    input  logic                   i_instr_mem_wr_rdy,
    output logic [ADDR_W-1:0]      o_instr_mem_wr_addr,
    output logic [INSTR_W-1:0]     o_instr_mem_wr_data,
    output logic                   o_instr_mem_wr_finish,
    input  logic [1:0]             i_work_state,
    output logic                   o_line_mem_rd_rdy,
    output logic [LINE_ADDR_W-1:0] o_line_mem_rd_addr,
    input  logic [LINE_W-1:0]      i_line_mem_rd_data,
    output logic                   o_rb_vld,
    input  logic                   i_rb_rdy,
    output logic [LINE_W-1:0]      o_rb_data,
    output logic                   o_rb_last,
    output logic [31:0]            o_cycle_cnt,
    output logic                   o_busy,
    output logic                   o_timeout
);

    state_t                 state;
    logic [ADDR_W:0]        word_cnt;
    logic [ADDR_W:0]        idx;
    logic [ADDR_W:0]        idx_nxt;
    logic [LINE_ADDR_W:0]   rb_left;
    logic [LINE_ADDR_W-1:0] rd_addr;
    logic [LINE_W-1:0]      rb_data;
    logic [31:0]            cycle_cnt;
    logic                   finish;
    logic                   timeout;

    logic pk_clr;
    logic pk_in_vld;
    logic pk_in_rdy;
    logic pk_in_last;
    logic pk_out_vld;
    logic pk_out_rdy;
    logic byte_fire;

    assign pk_clr     = (state == ST_IDLE) && i_start;
    assign pk_in_vld  = (state == ST_PACK) && i_byte_vld;
    assign pk_out_rdy = (state == ST_WRITE) && i_instr_mem_wr_rdy;
    assign byte_fire  = pk_in_vld && pk_in_rdy;
    assign idx_nxt    = idx + (ADDR_W + 1)'(1);

    wasm_byte_packer #(
        .WORD_W(INSTR_W)
    ) u_packer (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (pk_clr),
        .in_vld  (pk_in_vld),
        .in_rdy  (pk_in_rdy),
        .in_data (i_byte_data),
        .in_last (pk_in_last),
        .out_vld (pk_out_vld),
        .out_rdy (pk_out_rdy),
        .out_data(o_instr_mem_wr_data)
    );

    // Every output decodes state/datapath registers only; no input reaches an output.
    assign o_byte_rdy            = (state == ST_PACK) && pk_in_rdy;
    assign o_instr_mem_wr_vld    = (state == ST_WRITE) && pk_out_vld;
    assign o_instr_mem_wr_addr   = idx[ADDR_W-1:0];
    assign o_instr_mem_wr_finish = finish;
    assign o_line_mem_rd_rdy     = (state == ST_RADDR);
    assign o_line_mem_rd_addr    = rd_addr;
    assign o_rb_vld              = (state == ST_OUT);
    assign o_rb_data             = rb_data;
    assign o_rb_last             = (state == ST_OUT) && (rb_left == (LINE_ADDR_W + 1)'(1));
    assign o_cycle_cnt           = cycle_cnt;
    assign o_busy                = (state != ST_IDLE);
    assign o_timeout             = timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            idx       <= '0;
            rb_left   <= '0;
            rd_addr   <= '0;
            rb_data   <= '0;
            cycle_cnt <= '0;
            finish    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        word_cnt  <= i_word_count;
                        rb_left   <= i_rb_count;
                        rd_addr   <= i_rb_base;
                        idx       <= '0;
                        cycle_cnt <= '0;
                        timeout   <= 1'b0;
                        if (i_word_count == '0) begin
                            finish <= 1'b1;
                            state  <= ST_FIN;
                        end else begin
                            finish <= 1'b0;
                            state  <= ST_PACK;
                        end
                    end
                end
                ST_PACK: begin
                    if (byte_fire && pk_in_last) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_instr_mem_wr_rdy) begin
                        idx <= idx_nxt;
                        if (idx_nxt == word_cnt) begin
                            finish <= 1'b1;
                            state  <= ST_FIN;
                        end else begin
                            state <= ST_PACK;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                    end
                    // completion wins over a timeout landing on the same cycle
                    if (i_work_state == WS_DONE) begin
                        state <= (rb_left == '0) ? ST_IDLE : ST_RADDR;
                    end else if (cycle_cnt == 32'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_RADDR: begin
                    state <= ST_RDATA;
                end
                ST_RDATA: begin
                    rb_data <= i_line_mem_rd_data;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_rb_rdy) begin
                        rd_addr <= rd_addr + LINE_ADDR_W'(1);
                        rb_left <= rb_left - (LINE_ADDR_W + 1)'(1);
                        state   <= (rb_left == (LINE_ADDR_W + 1)'(1)) ? ST_IDLE : ST_RADDR;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wasm_host_loader.md
# wasm_host_loader

Host-side sequencer that packs an incoming byte stream into instruction words, writes them into the WASM core's instruction memory over its valid/ready port, and raises the write-finish strobe. It then waits for the core to report completion and reads a contiguous range of line memory back out as a valid/ready result stream. It sits between the host/debug link and `WASM_TOP`, replacing the hard-wired load/readback sequencing with a parametrised, timeout-protected engine.

## Interface
- `INSTR_W`, 64: instruction word width; must be a multiple of 8. Bytes per word is `NB = INSTR_W/8`.
- `ADDR_W`, 15: instruction memory address width.
- `LINE_ADDR_W`, 9: line memory address width.
- `LINE_W`, 32: line memory data width.
- `TIMEOUT`, 2^24: maximum wait-for-done cycles.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; one clock, synchronous, active-high.
- `i_start`  in  1  one-cycle pulse that latches all `i_*_count`/`i_rb_base` values; ignored unless in IDLE.
- `i_word_count`  in  ADDR_W+1  number of instruction words to load.
- `i_rb_base`  in  LINE_ADDR_W  first line memory address to read back.
- `i_rb_count`  in  LINE_ADDR_W+1  number of words to read back.
- `i_byte_vld` / `o_byte_rdy` / `i_byte_data`  in/out/in  1/1/8  byte stream, little-endian.
- `o_instr_mem_wr_vld` / `i_instr_mem_wr_rdy`  out/in  1/1  instruction write handshake.
- `o_instr_mem_wr_addr` / `o_instr_mem_wr_data`  out  ADDR_W/INSTR_W  write address and data.
- `o_instr_mem_wr_finish`  out  1  level; high from the end of the load until the next `i_start`.
- `i_work_state`  in  2  core state; `2'b11` means done.
- `o_line_mem_rd_rdy` / `o_line_mem_rd_addr` / `i_line_mem_rd_data`  out/out/in  1/LINE_ADDR_W/LINE_W  line memory read port. Read latency is 1 cycle.
- `o_rb_vld` / `i_rb_rdy` / `o_rb_data` / `o_rb_last`  out/in/out/out  1/1/LINE_W/1  readback stream.
- `o_cycle_cnt`  out  32  cycles counted from finish to done.
- `o_busy`, `o_timeout`  out  1  status.

## Operation
**States:** IDLE → PACK → WRITE → (PACK | FIN) → WAIT → RADDR → RDATA → OUT → (RADDR | IDLE).

- **IDLE**
  - `o_byte_rdy` = 0, `o_busy` = 0.
  - On `i_start`: latch all parameters, clear counters and `o_timeout`.
  - Next state: PACK if `i_word_count` ≠ 0, otherwise FIN.
- **PACK**
  - `o_byte_rdy` = 1.
  - Byte k of the current word (k = 0..NB-1) is placed in bits [8k+7:8k].
  - After NB accepted bytes, go to WRITE.
- **WRITE**
  - `o_instr_mem_wr_vld` = 1; address = word index, starting at 0.
  - Address and data are held stable until `i_instr_mem_wr_rdy`.
  - On the handshake: increment the index. If it equals the word count go to FIN, otherwise go to PACK.
- **FIN**
  - Assert `o_instr_mem_wr_finish` and go to WAIT.
- **WAIT**
  - `o_cycle_cnt` increments every cycle, saturating at all-ones.
  - If `i_work_state == 2'b11`, go to RADDR, or to IDLE when `i_rb_count` = 0.
  - If TIMEOUT cycles elapse first, set `o_timeout` (sticky until the next `i_start`) and go to IDLE.
- **RADDR**
  - Drive `o_line_mem_rd_rdy` = 1 with address `i_rb_base` + offset, wrapping modulo 2^LINE_ADDR_W.
- **RDATA**
  - Capture `i_line_mem_rd_data` into the output register.
- **OUT**
  - `o_rb_vld` = 1; `o_rb_last` = 1 on the final word.
  - On `i_rb_rdy`, either advance the offset and go to RADDR, or go to IDLE after the last word.

## Timing
- **Reset values:** all outputs 0, state IDLE, `o_cycle_cnt` = 0.
- **Reset mid-operation:** `i_rst` in any state aborts the operation next edge, with no partial write.
- **Registered outputs:** all outputs are registered; there is no combinational path from any input to any output.
- **Write throughput:** one instruction word per NB+1 cycles minimum (NB byte cycles plus 1 write cycle).
- **Readback throughput:** 3 cycles per word minimum (RADDR, RDATA, OUT), plus any back-pressure from `i_rb_rdy`.
- **Write stall:** if `i_instr_mem_wr_rdy` is low, WRITE holds indefinitely and `o_byte_rdy` stays 0.
- **Byte gaps:** idle cycles on `i_byte_vld` are allowed mid-word; the partially packed word is retained.
- **FIN to WAIT:** `o_cycle_cnt` starts counting the cycle after `o_instr_mem_wr_finish` rises.
- **`i_start` while busy:** ignored.

## Structure
- Shared package `wasm_host_pkg` holds:
  - the state enum;
  - the `WS_DONE = 2'b11` constant;
  - default parameter values.
- Single sub-module `wasm_byte_packer` performs byte→word packing, with its own `vld`/`rdy` on both sides. It is instantiated once.
- The FSM, counters and readback logic live in the top.

## Test plan
- **Basic load:** `INSTR_W`=64, `i_word_count`=2, bytes 0x00..0x0F, `i_instr_mem_wr_rdy` tied 1 → writes `addr0=0x0706050403020100` and `addr1=0x0F0E0D0C0B0A0908`; `o_instr_mem_wr_finish` rises.
- **Back-pressure:** `i_instr_mem_wr_rdy` low for 5 cycles during WRITE → address and data held stable, `o_byte_rdy`=0, no word lost.
- **Zero counts:** `i_word_count`=0 → FIN the cycle after `i_start`, with no writes. `i_rb_count`=0 → return to IDLE on done, `o_rb_vld` never asserts.
- **Readback with wrap:** `i_rb_base`=0x1FE, `i_rb_count`=3, line memory preloaded 0x1FE→0xA, 0x1FF→0xB, 0x000→0xC → stream A, B, C with `o_rb_last` on C; `o_cycle_cnt` equals the cycles from finish until `i_work_state`=2'b11.
- **Timeout:** `TIMEOUT`=100, `i_work_state` never reaches 2'b11 → `o_timeout`=1 after 100 WAIT cycles, state IDLE, and `o_timeout` clears on the next `i_start`.
- **Reset mid-operation:** assert `i_rst` in the middle of a WRITE stall → all outputs are 0 next cycle, and a subsequent `i_start` performs a clean load.
